// File: rtl/store_buffer_pkg.sv
// Shared types for the posted-write store buffer.
// Entry layout, default widths and index width.
package store_buffer_pkg;

    localparam int WORD_W   = 64;
    localparam int SB_AW    = 64;
    localparam int SB_DEPTH = 4;
    localparam int SB_IDX_W = $clog2(SB_DEPTH);

    typedef struct packed {
        logic              valid;
        logic [SB_AW-1:0]  addr;
        logic [WORD_W-1:0] data;
    } sb_entry;

endpackage

// File: rtl/store_buffer_match.sv
// Youngest-first forwarding match over the store buffer entries.
// Ports: ent (entries), head (oldest index), key (word address) -> hit, data.
module sb_forward_match
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH = SB_DEPTH,
    parameter  int AW    = SB_AW,
    localparam int IW    = $clog2(DEPTH)
) (
    input  sb_entry           ent [DEPTH],
    input  logic [IW-1:0]     head,
    input  logic [AW-3:0]     key,
    output logic              hit,
    output logic [WORD_W-1:0] data
);

    logic [IW-1:0] idx;

    // Walk oldest to youngest; a later match overrides, so youngest wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + IW'(i);
            if (ent[idx].valid &&
                (ent[idx].addr >> 2) == SB_AW'(key)) begin
                hit  = 1'b1;
                data = ent[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the datapath and unified memory.
// Ports: CLK/RST; cpu_* request side; mem_* memory side; stall, empty.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = WORD_W
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wd,
    input  logic          cpu_we,
    input  logic          cpu_re,
    output logic [DW-1:0] cpu_rd,
    output logic          stall,
    output logic          empty,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd,
    input  logic          mem_ready
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    sb_entry           ent_q [DEPTH];
    sb_entry           ent_d [DEPTH];
    logic [IW-1:0]     head_q, head_d;
    logic [IW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full, pop, push, hit;
    logic [WORD_W-1:0] fwd_data;

    sb_forward_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_match (
        .ent   (ent_q),
        .head  (head_q),
        .key   (cpu_addr[AW-1:2]),
        .hit   (hit),
        .data  (fwd_data)
    );

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Reads own the port; otherwise drain the head entry.
    // mem_we deliberately ignores mem_ready.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = cpu_addr;
        mem_wd   = '0;
        if (!cpu_re && !empty) begin
            mem_we   = 1'b1;
            mem_addr = ent_q[head_q].addr[AW-1:0];
            mem_wd   = ent_q[head_q].data[DW-1:0];
        end
    end

    assign pop   = mem_we & mem_ready;
    assign push  = cpu_we & (~full | pop);
    assign stall = cpu_we & full & ~pop;

    // Forwarded data reflects pre-edge contents only.
    assign cpu_rd = (cpu_re && hit) ? fwd_data[DW-1:0] : mem_rd;

    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        // Pop before push: at full, tail==head and the push must win.
        if (pop) begin
            ent_d[head_q].valid = 1'b0;
            head_d = head_q + IW'(1);
        end
        if (push) begin
            ent_d[tail_q].valid = 1'b1;
            ent_d[tail_q].addr  = SB_AW'(cpu_addr);
            ent_d[tail_q].data  = WORD_W'(cpu_wd);
            tail_d = tail_q + IW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer.
// Queue model checked every cycle plus directed literal checks.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam logic [63:0] K = 64'h5A5A_0000_0000_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic [63:0] cpu_addr, cpu_wd, cpu_rd;
    logic        cpu_we, cpu_re;
    logic        stall, empty;
    logic [63:0] mem_addr, mem_wd, mem_rd;
    logic        mem_we, mem_ready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
    } ment_t;

    ment_t q[$];

    store_buffer #(.DEPTH(DEPTH), .AW(64), .DW(64)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cpu_addr  (cpu_addr),
        .cpu_wd    (cpu_wd),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_rd    (cpu_rd),
        .stall     (stall),
        .empty     (empty),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd),
        .mem_ready (mem_ready)
    );

    always #5 CLK = ~CLK;

    // Memory returns a value derived from the address it is given.
    assign mem_rd = mem_addr ^ K;

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
        end
    endtask

    // Model update on each edge from the pre-edge inputs.
    always @(posedge CLK) begin
        if (RST) begin
            q.delete();
        end else begin
            bit p, w;
            p = !cpu_re && q.size() > 0 && mem_ready;
            w = cpu_we && (q.size() < DEPTH || p);
            if (p) void'(q.pop_front());
            if (w) q.push_back('{cpu_addr, cpu_wd});
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge CLK) begin
        if (!RST) begin
            logic        e_we, e_stall;
            logic [63:0] e_addr, e_rd;
            e_we   = !cpu_re && q.size() > 0;
            e_addr = e_we ? q[0].a : cpu_addr;
            e_stall = cpu_we && q.size() == DEPTH && !(e_we && mem_ready);
            e_rd   = e_addr ^ K;
            if (cpu_re) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i].a[63:2] == cpu_addr[63:2]) e_rd = q[i].d;
                end
            end
            chk("m_mem_we", {63'd0, mem_we}, {63'd0, e_we});
            chk("m_mem_addr", mem_addr, e_addr);
            if (!cpu_re) chk("m_mem_wd", mem_wd, e_we ? q[0].d : 64'd0);
            chk("m_stall", {63'd0, stall}, {63'd0, e_stall});
            chk("m_empty", {63'd0, empty}, {63'd0, q.size() == 0});
            chk("m_cpu_rd", cpu_rd, e_rd);
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        cpu_we = 1'b0;
        cpu_re = 1'b0;
    endtask

    task automatic st(input logic [63:0] a, input logic [63:0] d);
        cpu_we   = 1'b1;
        cpu_re   = 1'b0;
        cpu_addr = a;
        cpu_wd   = d;
        cyc();
    endtask

    task automatic rd(input logic [63:0] a);
        cpu_we   = 1'b0;
        cpu_re   = 1'b1;
        cpu_addr = a;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        cpu_addr = 64'h1234; cpu_wd = '0;
        cpu_we = 1'b0; cpu_re = 1'b0; mem_ready = 1'b0;
        cyc(); cyc();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_empty", {63'd0, empty}, 64'd1);
        chk("rst_we", {63'd0, mem_we}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_addr", mem_addr, 64'h1234);
        chk("rst_rd", cpu_rd, 64'h1234 ^ K);

        // Single store drain.
        mem_ready = 1'b1;
        cyc();
        st(64'h40, 64'hDEAD);
        idle();
        @(negedge CLK);
        chk("t1_we", {63'd0, mem_we}, 64'd1);
        chk("t1_addr", mem_addr, 64'h40);
        chk("t1_wd", mem_wd, 64'hDEAD);
        cyc();
        @(negedge CLK);
        chk("t1_empty", {63'd0, empty}, 64'd1);

        // Forward youngest.
        mem_ready = 1'b0;
        st(64'h80, 64'd1);
        st(64'h80, 64'd2);
        rd(64'h80);
        @(negedge CLK);
        chk("t2_fwd", cpu_rd, 64'd2);
        cyc(); rd(64'h82);
        @(negedge CLK);
        chk("t2_lowbits", cpu_rd, 64'd2);
        cyc(); rd(64'h84);
        @(negedge CLK);
        chk("t2_miss", cpu_rd, 64'h84 ^ K);
        cyc(); idle(); mem_ready = 1'b1;
        @(negedge CLK);
        chk("t2_first", mem_wd, 64'd1);
        cyc();
        @(negedge CLK);
        chk("t2_second", mem_wd, 64'd2);
        cyc();

        // Full / stall.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) st(64'h100 + 64'(4 * i), 64'h10 + 64'(i));
        cpu_we = 1'b1; cpu_addr = 64'h110; cpu_wd = 64'h14;
        @(negedge CLK);
        chk("t3_stall", {63'd0, stall}, 64'd1);
        cyc();
        @(negedge CLK);
        chk("t3_stall_hold", {63'd0, stall}, 64'd1);
        cyc(); mem_ready = 1'b1;
        @(negedge CLK);
        chk("t3_nostall", {63'd0, stall}, 64'd0);
        chk("t3_pop_wd", mem_wd, 64'h10);
        cyc(); idle();
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            chk("t3_drain", mem_wd, 64'h10 + 64'(i));
            cyc();
        end
        @(negedge CLK);
        chk("t3_empty", {63'd0, empty}, 64'd1);

        // Read blocks drain.
        mem_ready = 1'b0;
        st(64'h200, 64'hA);
        st(64'h204, 64'hB);
        mem_ready = 1'b1;
        rd(64'h300);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("t4_blocked", {63'd0, mem_we}, 64'd0);
            chk("t4_pending", {63'd0, empty}, 64'd0);
            cyc();
        end
        idle();
        @(negedge CLK);
        chk("t4_resume", mem_wd, 64'hA);
        cyc(); cyc();

        // Reset mid-operation.
        mem_ready = 1'b0;
        st(64'h400, 64'h1);
        st(64'h404, 64'h2);
        st(64'h408, 64'h3);
        idle(); mem_ready = 1'b1; RST = 1'b1;
        cyc(); RST = 1'b0;
        @(negedge CLK);
        chk("t5_we", {63'd0, mem_we}, 64'd0);
        chk("t5_empty", {63'd0, empty}, 64'd1);
        rd(64'h404);
        @(negedge CLK);
        chk("t5_rd", cpu_rd, 64'h404 ^ K);
        cyc();

        // Read + write same cycle.
        mem_ready = 1'b0;
        st(64'hC0, 64'd5);
        cpu_re = 1'b1; cpu_we = 1'b1; cpu_addr = 64'hC0; cpu_wd = 64'd9;
        @(negedge CLK);
        chk("t6_old", cpu_rd, 64'd5);
        cyc(); rd(64'hC0);
        @(negedge CLK);
        chk("t6_new", cpu_rd, 64'd9);
        cyc(); idle(); mem_ready = 1'b1;
        cyc(); cyc(); cyc();
        @(negedge CLK);
        chk("t6_empty", {63'd0, empty}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
